// File: rtl/special_reg_unit.sv
// Special-register responder for MTS/MFS: one request in, one response out,
// with the core ID, a free-running cycle counter and scratch registers.
module special_reg_unit #(
  parameter int          NUM_SREG = 8,
  parameter logic [31:0] CORE_ID  = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] cycle_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a request is taken only in IDLE, and the response is held
  // unchanged in RESP until rsp_ready is seen.
  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        is_mts, is_mfs, idx_ok, illegal;
  logic [4:0]  idx;
  logic [31:0] rd_val;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] sr_val [NUM_SREG];

  assign is_mts  = (req_insn[31:23] == 9'd0) && (req_insn[7:0] == 8'h0D);
  assign is_mfs  = (req_insn[31:23] == 9'd0) && (req_insn[7:0] == 8'h0C);
  assign idx     = req_insn[12:8];
  assign idx_ok  = {27'd0, idx} < 32'(NUM_SREG);
  assign illegal = !(is_mts || is_mfs) || !idx_ok || (is_mts && idx == 5'd0);
  assign accept  = (state_q == S_IDLE) && req_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    cycle_cnt = cnt_q;
  end

  assign sr_val[0] = CORE_ID;
  assign sr_val[1] = cnt_q;

  genvar g;
  for (g = 2; g < NUM_SREG; g++) begin : g_scratch
    logic [31:0] val_q;
    logic        wr_en;
    assign wr_en = accept && !illegal && is_mts && (idx == 5'(g));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     val_q <= 32'd0;
      else if (wr_en) val_q <= req_wdata;
    end
    assign sr_val[g] = val_q;
  end

  always_comb begin
    rd_val = 32'd0;
    for (int i = 0; i < NUM_SREG; i++) begin
      if (idx == 5'(i)) rd_val = sr_val[i];
    end
  end

  // An MTS to SR1 replaces that cycle's increment.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (accept && !illegal && is_mts && idx == 5'd1) cnt_d = req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      rdata_d = (is_mfs && !illegal) ? rd_val : 32'd0;
      err_d   = illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_special_reg_unit.sv
// Directed bench for special_reg_unit: expected {err,rdata} pairs are queued
// when a request is driven and checked when the response appears.
module tb_special_reg_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_insn, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] cycle_cnt;

  logic [32:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  special_reg_unit #(.NUM_SREG(8), .CORE_ID(32'h0000_0001)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_insn  (req_insn),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the next negedge,
  // where the response must already be valid.
  task automatic issue(input logic [31:0] insn, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_insn  = insn;
    req_wdata = wdata;
    exp_q.push_back({err, rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_insn  = $urandom;
    req_wdata = $urandom;
    chk("latency_rsp_valid", 64'(rsp_valid), 64'(1));
  endtask

  // Compares the held response against the scoreboard, then completes the
  // handshake and returns one negedge later.
  task automatic collect(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle"}, 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
  endtask

  logic [31:0] scr [8];

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_insn  = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {28'd0, req_ready, rsp_valid, rsp_err, 1'b0, rsp_rdata},
        {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    chk("reset_cnt", 64'(cycle_cnt), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("cnt_runs", 64'(cycle_cnt), 64'(1));

    // Core ID read
    issue(32'h0000_000C, 32'd0, 1'b0, 32'h0000_0001);
    collect("mfs_sr0");

    // Scratch write/read
    issue(32'h0000_030D, 32'hDEAD_BEEF, 1'b0, 32'd0);
    collect("mts_sr3");
    issue(32'h0000_030C, 32'd0, 1'b0, 32'hDEAD_BEEF);
    collect("mfs_sr3");

    // Counter override and wrap
    issue(32'h0000_010D, 32'hFFFF_FFFE, 1'b0, 32'd0);
    chk("cnt_after_write", 64'(cycle_cnt), 64'(32'hFFFF_FFFE));
    collect("mts_sr1");
    chk("cnt_plus1", 64'(cycle_cnt), 64'(32'hFFFF_FFFF));
    issue(32'h0000_010C, 32'd0, 1'b0, 32'hFFFF_FFFF);
    chk("cnt_wrap", 64'(cycle_cnt), 64'(0));
    collect("mfs_sr1");

    // Error cases, none of which may change state
    issue(32'h0000_000D, 32'h1234_5678, 1'b1, 32'd0);
    collect("err_mts_sr0");
    issue(32'h0000_080C, 32'd0, 1'b1, 32'd0);
    collect("err_mfs_idx8");
    issue(32'h0000_080D, 32'h5555_AAAA, 1'b1, 32'd0);
    collect("err_mts_idx8");
    issue(32'h0000_0001, 32'd0, 1'b1, 32'd0);
    collect("err_nop");
    issue(32'h0080_030C, 32'd0, 1'b1, 32'd0);
    collect("err_high_bits");
    issue(32'h0000_000C, 32'd0, 1'b0, 32'h0000_0001);
    collect("mfs_sr0_after_err");
    issue(32'h0000_030C, 32'd0, 1'b0, 32'hDEAD_BEEF);
    collect("mfs_sr3_after_err");

    // Random data through every scratch register
    for (int i = 2; i < 8; i++) begin
      scr[i] = $urandom;
      issue({19'd0, 5'(i), 8'h0D}, scr[i], 1'b0, 32'd0);
      collect("mts_scratch");
    end
    for (int i = 7; i >= 2; i--) begin
      issue({19'd0, 5'(i), 8'h0C}, 32'd0, 1'b0, scr[i]);
      collect("mfs_scratch");
    end

    // Back-pressure with a pending request behind it
    rsp_ready = 1'b0;
    issue(32'h0000_050C, 32'd0, 1'b0, scr[5]);
    req_valid = 1'b1;
    req_insn  = 32'h0000_000C;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {30'd0, rsp_valid, req_ready, rsp_err, rsp_rdata[30:0]},
          {30'd0, 1'b1, 1'b0, 1'b0, scr[5][30:0]});
      chk("bp_rdata_msb", 64'(rsp_rdata[31]), 64'(scr[5][31]));
      @(negedge clk);
    end
    begin
      logic [32:0] e;
      e = exp_q.pop_front();
      chk("bp_rsp", {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_not_yet_accepted", 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
    exp_q.push_back({1'b0, 32'h0000_0001});
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_pending_latency", 64'(rsp_valid), 64'(1));
    collect("bp_pending_mfs_sr0");

    // Reset while a response is outstanding
    rsp_ready = 1'b0;
    issue(32'h0000_040D, 32'h1234_5678, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp", {29'd0, rsp_valid, req_ready, rsp_err, rsp_rdata},
        {29'd0, 1'b0, 1'b1, 1'b0, 32'd0});
    chk("rst_mid_cnt", 64'(cycle_cnt), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    issue(32'h0000_030C, 32'd0, 1'b0, 32'd0);
    collect("post_rst_sr3");
    issue(32'h0000_040C, 32'd0, 1'b0, 32'd0);
    collect("post_rst_sr4");
    issue(32'h0000_000C, 32'd0, 1'b0, 32'h0000_0001);
    collect("post_rst_sr0");

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/special_reg_unit.md
Name: special_reg_unit

Overview:
- Execution-side responder for decoded MTS (move-to-special, op[7:0]=0x0D) and MFS (move-from-special, op[7:0]=0x0C) instructions, both with op[31:23]=0.
- Accepts one instruction per transaction over a valid/ready request channel, performs the special-register access and returns the result over a valid/ready response channel.
- Holds the core's special-register file: a read-only ID register, a free-running cycle counter and general scratch registers.

Parameters:
- NUM_SREG, 8, number of special registers implemented (2..32); indices at or above NUM_SREG do not exist.
- CORE_ID, 32'h0000_0001, constant value returned by SR0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_insn  in  32  instruction opcode
- req_wdata  in  32  source GPR value for MTS (ignored for MFS)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  MFS read value; 0 for MTS and errors
- rsp_err  out  1  illegal access
- cycle_cnt  out  32  live SR1 value, for debug and trace

Behaviour:
- Decode:
  - is_mts = (req_insn[31:23]==0) & (req_insn[7:0]==8'h0D).
  - is_mfs = (req_insn[31:23]==0) & (req_insn[7:0]==8'h0C).
  - Register index = req_insn[12:8].
- Register map:
  - SR0: read-only, reads CORE_ID.
  - SR1: cycle counter, increments by 1 every clock and wraps 0xFFFF_FFFF -> 0.
  - SR2..SR(NUM_SREG-1): 32-bit read/write scratch registers.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - SR1 = 0, all scratch registers = 0.
- FSM states: IDLE, RESP.
  - IDLE: req_ready = 1. On req_valid (accept cycle N), execute the access, capture the response, go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1. When rsp_ready is high, go to IDLE.
- Timing and handshake:
  - Fixed latency: rsp_valid rises in cycle N+1.
  - Maximum throughput is one transaction per 2 cycles. There is no bypass of RESP, and req_ready does not depend combinationally on rsp_ready.
  - rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
  - req_insn and req_wdata are sampled only at acceptance.
- MFS:
  - rsp_rdata = register value as of the accept cycle. For SR1 this is the counter value before that cycle's increment.
- MTS:
  - The write takes effect at the end of the accept cycle.
  - A write to SR1 overrides that cycle's increment: SR1 = req_wdata in cycle N+1, req_wdata+1 in N+2.
  - rsp_rdata = 0.
- Errors (rsp_err=1, rsp_rdata=0, no state change):
  - index >= NUM_SREG;
  - MTS to SR0;
  - an instruction that is neither MTS nor MFS.
- The SR1 counter keeps running in both states, and while a response is stalled.
- Reset asserted mid-transaction: the pending response is dropped and everything returns to reset values immediately. After deassertion, the first request is accepted normally.

Test Plan:
1. Reset, then MFS with index 0 (insn 32'h0000_000C) -> rsp_valid in the next cycle, rsp_rdata=32'h0000_0001, rsp_err=0.
2. MTS SR3 (insn 32'h0000_030D, wdata 32'hDEAD_BEEF), then MFS SR3 (32'h0000_030C) -> second rsp_rdata=32'hDEAD_BEEF, both rsp_err=0.
3. MTS SR1 with wdata 32'hFFFF_FFFE, then immediately MFS SR1 once the unit is ready -> cycle_cnt shows FFFF_FFFE, FFFF_FFFF, 0000_0000 across consecutive cycles; the read returns the counter value at its own accept cycle (wrap checked).
4. Error cases: MTS SR0, MFS index 8 with NUM_SREG=8, and insn 32'h0000_0001 (NOP) -> each gives rsp_err=1, rsp_rdata=0; a subsequent MFS SR0 still reads CORE_ID.
5. Back-pressure: hold rsp_ready=0 for 5 cycles after a response -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a pending req_valid is not accepted until one cycle after the rsp handshake.
6. Assert rst_n low while in RESP -> rsp_valid=0 and req_ready=1 immediately, scratch registers read 0 after reset.
